// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between two requesters.
// Each grant becomes a 4-byte frame: header, data hi, data lo, checksum.
module uart_tx_sched #(
  parameter logic [7:0] HDR_BASE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  gnt,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t          state;
  logic [1:0]      byte_idx;
  logic            last_gnt;
  logic            tx_done_q;
  logic [3:0][7:0] frame_q;

  logic            win;
  logic [15:0]     win_data;
  logic [7:0]      hdr;
  logic [7:0]      csum;
  logic [3:0][7:0] frame_nxt;
  logic            done_rise;

  always_comb begin
    win = ~last_gnt;
    if (req == 2'b01) begin
      win = 1'b0;
    end else if (req == 2'b10) begin
      win = 1'b1;
    end
  end

  assign win_data  = win ? data1 : data0;
  assign hdr       = HDR_BASE + {7'd0, win};
  assign csum      = ~(hdr + win_data[15:8] + win_data[7:0]);
  assign frame_nxt = {csum, win_data[7:0], win_data[15:8], hdr};

  // a level left high by the previous byte must not count as completion
  assign done_rise = tx_done & ~tx_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      trmt       <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      byte_idx   <= 2'd0;
      last_gnt   <= 1'b1;
      tx_done_q  <= 1'b0;
      frame_q    <= '0;
    end else begin
      tx_done_q  <= tx_done;
      gnt        <= 2'b00;
      trmt       <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            state    <= SEND;
            busy     <= 1'b1;
            gnt      <= win ? 2'b10 : 2'b01;
            last_gnt <= win;
            byte_idx <= 2'd0;
            frame_q  <= frame_nxt;
            trmt     <= 1'b1;
            tx_data  <= frame_nxt[0];
          end
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            if (byte_idx == 2'd3) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= SEND;
              trmt     <= 1'b1;
              tx_data  <= frame_q[byte_idx + 2'd1];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a frame-level model
// with a stub transmitter that keeps tx_done high between bytes.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] data0 = 16'h0000;
  logic [15:0] data1 = 16'h0000;
  logic [1:0]  gnt;
  logic        tx_done;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        busy;
  logic        frame_done;

  uart_tx_sched #(.HDR_BASE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(data0), .data1(data1), .gnt(gnt),
    .tx_done(tx_done), .trmt(trmt), .tx_data(tx_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stub transmitter: done level drops after trmt, rises a few cycles later
  logic [7:0] txq[$];
  int tcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b1;
      tcnt    <= 0;
    end else if (trmt) begin
      txq.push_back(tx_data);
      tx_done <= 1'b0;
      tcnt    <= int'($urandom_range(3, 12));
    end else if (tcnt > 0) begin
      tcnt <= tcnt - 1;
      if (tcnt == 1) tx_done <= 1'b1;
    end
  end

  int n_fd = 0, n_trmt = 0;
  int v_onehot = 0, v_gfd = 0, v_trmt_busy = 0, v_busy = 0;
  bit in_frame = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0;
    end else begin
      if (frame_done) n_fd++;
      if (trmt) n_trmt++;
      if (gnt == 2'b11) v_onehot++;
      if (|gnt && frame_done) v_gfd++;
      if (trmt && !busy) v_trmt_busy++;
      if (frame_done) in_frame = 0;
      if (in_frame && !busy) v_busy++;
      if (|gnt) in_frame = 1;
    end
  end

  // reference model: round robin over the last winner, bytes by arithmetic
  int last_w = 1;
  int frames = 0;
  int trmts_exp = 0;

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return (last_w == 0) ? 1 : 0;
  endfunction

  function automatic logic [31:0] frame_of(input int w, input int d);
    int h, hi, lo, c;
    h  = (165 + w) % 256;
    hi = d / 256;
    lo = d % 256;
    c  = 255 - ((h + hi + lo) % 256);
    return (h << 24) | (hi << 16) | (lo << 8) | c;
  endfunction

  task automatic do_frame(input logic [1:0] r, input logic [15:0] d0,
                          input logic [15:0] d1, input bit keep_req,
                          input bit change);
    int t, w;
    logic [31:0] exp, got;
    req = r;
    data0 = d0;
    data1 = d1;
    w = pick(r);
    @(negedge clk);
    t = 0;
    while (gnt == 2'b00 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("gnt_lat", t, 0);
    chk("gnt", {30'd0, gnt}, (w == 1) ? 2 : 1);
    chk("trmt_first", {31'd0, trmt}, 1);
    chk("busy", {31'd0, busy}, 1);
    last_w = w;
    exp = frame_of(w, (w == 1) ? int'(d1) : int'(d0));
    if (!keep_req) req = 2'b00;
    @(negedge clk);
    chk("gnt_pulse", {30'd0, gnt}, 0);
    if (change) begin
      data0 = 16'hDEAD ^ 16'($urandom);
      data1 = 16'($urandom);
    end
    t = 0;
    while (!frame_done && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("fd_timeout", {31'd0, t < 400}, 1);
    chk("nbytes", txq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      got = (txq.size() > k) ? {24'd0, txq[k]} : 32'hFFFF_FFFF;
      chk($sformatf("byte%0d", k), got, (exp >> (24 - 8 * k)) & 255);
    end
    txq.delete();
    frames++;
    trmts_exp += 4;
  endtask

  task automatic reset_now();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_trmt", {31'd0, trmt}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_gnt", {30'd0, gnt}, 0);
    chk("rst_fd", {31'd0, frame_done}, 0);
    chk("rst_txd", {24'd0, tx_data}, 0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    txq.delete();
    #2 rst_n = 1'b1;
    last_w = 1;
    @(negedge clk);
  endtask

  initial begin
    int t, fd0;
    #12;
    chk("init_busy", {31'd0, busy}, 0);
    chk("init_gnt", {30'd0, gnt}, 0);
    chk("init_trmt", {31'd0, trmt}, 0);
    chk("init_txd", {24'd0, tx_data}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    do_frame(2'b01, 16'h1234, 16'h0000, 0, 1);
    do_frame(2'b10, 16'h0000, 16'hFF00, 0, 0);
    for (int i = 0; i < 4; i++)
      do_frame(2'b11, 16'h0001, 16'h0002, 1, 0);
    req = 2'b00;
    @(negedge clk);

    // reset while the second byte is on the wire
    req = 2'b01;
    data0 = 16'($urandom);
    t = 0;
    while (txq.size() < 2 && t < 200) begin
      @(negedge clk);
      t++;
      if (|gnt) req = 2'b00;
    end
    chk("mid_to", {31'd0, t < 200}, 1);
    trmts_exp += 2;
    fd0 = n_fd;
    reset_now();
    repeat (20) @(negedge clk);
    chk("no_fd_abandon", n_fd, fd0);
    do_frame(2'b10, 16'($urandom), 16'hBEEF, 0, 1);
    reset_now();
    do_frame(2'b11, 16'h5A5A, 16'hC3C3, 0, 0);

    for (int i = 0; i < 24; i++)
      do_frame(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    req = 2'b00;
    repeat (5) @(negedge clk);

    chk("fd_count", n_fd, frames);
    chk("trmt_count", n_trmt, trmts_exp);
    chk("gnt_onehot", v_onehot, 0);
    chk("gnt_fd_overlap", v_gfd, 0);
    chk("trmt_busy", v_trmt_busy, 0);
    chk("busy_frame", v_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
